// File: rtl/axis_uart_cfg_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_uart_cfg_if
//  Purpose  : AXI-Stream bundle used on both faces of axis_uart_cfg.
//             tdata carries one UART payload word. tuser carries per-word
//             status: bit0 = parity error, bit1 = framing error. tuser is
//             meaningful on the receive stream only.
//  Signals  : tdata [DATA_BITS], tuser [2], tvalid, tready
//  Modports : master drives tdata/tuser/tvalid; slave drives tready.
//  Revision : 1.0  initial release
// ============================================================================
interface axis_uart_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tdata;
    logic [1:0]           tuser;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_uart_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_uart_cfg
//  Purpose  : Parametrised AXI-Stream UART transceiver. The data width,
//             the parity mode and the number of stop bits are set by
//             parameters. The receiver oversamples at 16x and takes a
//             majority vote. Received words go into a first-word
//             fall-through FIFO and carry error flags on tuser.
//  Ports    : aclk        - system clock
//             areset      - synchronous active-high reset
//             uart_rx     - asynchronous serial input, idle high
//             uart_tx     - serial output, idle high
//             s_axis      - words to transmit (slave)
//             m_axis      - received words + {frame_err, parity_err} (master)
//             rx_overflow - one-cycle pulse when a frame is dropped
//  Revision : 1.0  initial release
// ============================================================================
module axis_uart_cfg #(
    parameter int CLOCK         = 100_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            uart_rx,
    output logic            uart_tx,
    axis_uart_cfg_if.slave  s_axis,
    axis_uart_cfg_if.master m_axis,
    output logic            rx_overflow
);
    // Divider rounded to nearest, never below 1
    localparam int c_div_raw = (CLOCK + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int c_div     = (c_div_raw < 1) ? 1 : c_div_raw;
    localparam int c_div_w   = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
    localparam logic [2:0] c_last_bit = 3'(DATA_BITS - 1);
    localparam logic c_odd    = (PARITY == 2);
    localparam int c_fifo_aw  = $clog2(RX_FIFO_DEPTH);
    localparam int c_fifo_w   = DATA_BITS + 2;

    // ------------------------------------------------------------------ tick
    logic [c_div_w-1:0] r_div_cnt;
    logic               w_tick;

    assign w_tick = (r_div_cnt == c_div_last);

    always_ff @(posedge aclk) begin
        if (areset)      r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

    // ------------------------------------------------------------ transmitter
    typedef enum logic [2:0] {
        TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PARITY = 3'd3, TX_STOP = 3'd4
    } tx_state_t;

    tx_state_t            r_tx_state, w_tx_state;
    logic [3:0]           r_tx_sub, w_tx_sub;
    logic [2:0]           r_tx_bit, w_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift;
    logic                 r_tx_par, w_tx_par;
    logic                 r_tx_stop2, w_tx_stop2;
    logic                 r_tx, w_tx;
    logic                 w_tx_bit_end;

    assign w_tx_bit_end  = w_tick && (r_tx_sub == 4'd15);
    assign s_axis.tready = (r_tx_state == TX_IDLE);
    assign uart_tx       = r_tx;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_tx_state <= TX_IDLE;
            r_tx_sub   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_stop2 <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_sub   <= w_tx_sub;
            r_tx_bit   <= w_tx_bit;
            r_tx_shift <= w_tx_shift;
            r_tx_par   <= w_tx_par;
            r_tx_stop2 <= w_tx_stop2;
            r_tx       <= w_tx;
        end
    end

    // The line level is registered. w_tx is the level for the state being entered.
    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_sub   = (w_tick && r_tx_state != TX_IDLE) ? r_tx_sub + 4'd1 : r_tx_sub;
        w_tx_bit   = r_tx_bit;
        w_tx_shift = r_tx_shift;
        w_tx_par   = r_tx_par;
        w_tx_stop2 = r_tx_stop2;
        w_tx       = r_tx;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx = 1'b1;
                if (s_axis.tvalid) begin
                    w_tx_shift = s_axis.tdata;
                    w_tx_par   = (^s_axis.tdata) ^ c_odd;
                    w_tx_sub   = 4'd0;
                    w_tx_state = TX_START;
                    w_tx       = 1'b0;
                end
            end
            TX_START: begin
                if (w_tx_bit_end) begin
                    w_tx_state = TX_DATA;
                    w_tx_bit   = 3'd0;
                    w_tx       = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (w_tx_bit_end) begin
                    w_tx_shift = r_tx_shift >> 1;
                    if (r_tx_bit == c_last_bit) begin
                        if (PARITY != 0) begin
                            w_tx_state = TX_PARITY;
                            w_tx       = r_tx_par;
                        end else begin
                            w_tx_state = TX_STOP;
                            w_tx_stop2 = 1'b0;
                            w_tx       = 1'b1;
                        end
                    end else begin
                        w_tx_bit = r_tx_bit + 3'd1;
                        w_tx     = r_tx_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (w_tx_bit_end) begin
                    w_tx_state = TX_STOP;
                    w_tx_stop2 = 1'b0;
                    w_tx       = 1'b1;
                end
            end
            TX_STOP: begin
                if (w_tx_bit_end) begin
                    if ((STOP_BITS == 2) && !r_tx_stop2) w_tx_stop2 = 1'b1;
                    else                                  w_tx_state = TX_IDLE;
                end
            end
            default: w_tx_state = TX_IDLE;
        endcase
    end

    // --------------------------------------------------------------- receiver
    typedef enum logic [2:0] {
        RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_PARITY = 3'd3, RX_STOP = 3'd4
    } rx_state_t;

    logic [1:0]           r_rx_sync;
    rx_state_t            r_rx_state, w_rx_state;
    logic [3:0]           r_rx_sub, w_rx_sub;
    logic [2:0]           r_rx_bit, w_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift;
    logic [1:0]           r_rx_smp, w_rx_smp;
    logic                 r_rx_perr, w_rx_perr;
    logic                 w_rx_in, w_rx_vote, w_rx_mid, w_rx_end;
    logic                 w_push, w_ferr;

    assign w_rx_in  = r_rx_sync[1];
    // r_rx_smp holds samples 7 and 8; the live input is sample 9
    assign w_rx_vote = (r_rx_smp[1] & r_rx_smp[0]) | (r_rx_smp[1] & w_rx_in) | (r_rx_smp[0] & w_rx_in);
    assign w_rx_mid  = w_tick && (r_rx_sub == 4'd9);
    assign w_rx_end  = w_tick && (r_rx_sub == 4'd15);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rx_sync  <= 2'b11;
            r_rx_state <= RX_IDLE;
            r_rx_sub   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_smp   <= 2'b11;
            r_rx_perr  <= 1'b0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], uart_rx};
            r_rx_state <= w_rx_state;
            r_rx_sub   <= w_rx_sub;
            r_rx_bit   <= w_rx_bit;
            r_rx_shift <= w_rx_shift;
            r_rx_smp   <= w_rx_smp;
            r_rx_perr  <= w_rx_perr;
        end
    end

    always_comb begin
        w_rx_state = r_rx_state;
        w_rx_sub   = (w_tick && r_rx_state != RX_IDLE) ? r_rx_sub + 4'd1 : r_rx_sub;
        w_rx_bit   = r_rx_bit;
        w_rx_shift = r_rx_shift;
        w_rx_perr  = r_rx_perr;
        w_rx_smp   = (w_tick && (r_rx_sub == 4'd7 || r_rx_sub == 4'd8)) ?
                     {r_rx_smp[0], w_rx_in} : r_rx_smp;
        w_push     = 1'b0;
        w_ferr     = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_tick && !w_rx_in) begin
                    w_rx_state = RX_START;
                    w_rx_sub   = 4'd0;
                    w_rx_perr  = 1'b0;
                end
            end
            RX_START: begin
                if (w_rx_mid && w_rx_vote) begin
                    w_rx_state = RX_IDLE;   // too short to be a start bit
                end else if (w_rx_end) begin
                    w_rx_state = RX_DATA;
                    w_rx_bit   = 3'd0;
                end
            end
            RX_DATA: begin
                if (w_rx_mid) w_rx_shift = {w_rx_vote, r_rx_shift[DATA_BITS-1:1]};
                if (w_rx_end) begin
                    if (r_rx_bit == c_last_bit) w_rx_state = (PARITY != 0) ? RX_PARITY : RX_STOP;
                    else                        w_rx_bit   = r_rx_bit + 3'd1;
                end
            end
            RX_PARITY: begin
                if (w_rx_mid) w_rx_perr = w_rx_vote ^ (^r_rx_shift) ^ c_odd;
                if (w_rx_end) w_rx_state = RX_STOP;
            end
            RX_STOP: begin
                // Finishing at mid-stop leaves the rest of the stop time to find the next start edge
                if (w_rx_mid) begin
                    w_push     = 1'b1;
                    w_ferr     = !w_rx_vote;
                    w_rx_state = RX_IDLE;
                end
            end
            default: w_rx_state = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- RX FIFO
    logic [c_fifo_w-1:0]  r_mem [RX_FIFO_DEPTH];
    logic [c_fifo_aw:0]   r_wr_ptr, r_rd_ptr;
    logic                 r_ovf;
    logic                 w_empty, w_full, w_pop, w_push_ok;
    logic [c_fifo_w-1:0]  w_head;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_fifo_aw] != r_rd_ptr[c_fifo_aw]) &&
                       (r_wr_ptr[c_fifo_aw-1:0] == r_rd_ptr[c_fifo_aw-1:0]);
    assign w_pop     = !w_empty && m_axis.tready;
    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_head    = r_mem[r_rd_ptr[c_fifo_aw-1:0]];

    always_ff @(posedge aclk) begin
        if (w_push_ok) r_mem[r_wr_ptr[c_fifo_aw-1:0]] <= {w_ferr, r_rx_perr, r_rx_shift};
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            r_ovf <= w_push && w_full && !w_pop;
        end
    end

    // The head is forced to zero when empty, so the outputs read 0 at reset without clearing the memory
    assign m_axis.tvalid = !w_empty;
    assign m_axis.tdata  = w_empty ? '0 : w_head[DATA_BITS-1:0];
    assign m_axis.tuser  = w_empty ? 2'b00 : w_head[c_fifo_w-1 -: 2];
    assign rx_overflow   = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_axis_uart_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_axis_uart_cfg
//  Purpose  : Directed self-checking bench for axis_uart_cfg. dut0 is set up
//             for 8N1 and dut1 for 7 data bits, even parity and 2 stop bits.
//             Both run at 16 clocks per bit. Each receive line is either
//             looped back from its transmitter or driven by the bench.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_uart_cfg;
    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic loop0, loop1, inj0, inj1;
    wire  tx0, tx1, ovf0, ovf1;
    wire  rx0 = loop0 ? tx0 : inj0;
    wire  rx1 = loop1 ? tx1 : inj1;

    axis_uart_cfg_if #(.DATA_BITS(8)) s0 ();
    axis_uart_cfg_if #(.DATA_BITS(8)) m0 ();
    axis_uart_cfg_if #(.DATA_BITS(7)) s1 ();
    axis_uart_cfg_if #(.DATA_BITS(7)) m1 ();

    axis_uart_cfg #(.CLOCK(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .RX_FIFO_DEPTH(16)) dut0 (
        .aclk(clk), .areset(rst), .uart_rx(rx0), .uart_tx(tx0),
        .s_axis(s0), .m_axis(m0), .rx_overflow(ovf0));

    axis_uart_cfg #(.CLOCK(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1),
                    .STOP_BITS(2), .RX_FIFO_DEPTH(16)) dut1 (
        .aclk(clk), .areset(rst), .uart_rx(rx1), .uart_tx(tx1),
        .s_axis(s1), .m_axis(m1), .rx_overflow(ovf1));

    int n_tests = 0;
    int n_fail  = 0;
    int ovf_cnt = 0;
    int ovf_frame = -1;
    int cur_frame = -1;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (ovf0 === 1'b1) begin
            ovf_cnt   = ovf_cnt + 1;
            ovf_frame = cur_frame;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line images, bit 0 = start bit, LSB first
    function automatic logic [15:0] frame8(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame7(input logic [6:0] d, input logic p, input logic stop1);
        return {5'b0, 1'b1, stop1, p, d, 1'b0};
    endfunction

    task automatic inj_frame(input int sel, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (sel == 0) inj0 = bits[i]; else inj1 = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int sel, input int budget, input string tag);
        int n;
        n = 0;
        while (((sel == 0) ? m0.tvalid : m1.tvalid) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, ((sel == 0) ? m0.tvalid : m1.tvalid)}, 32'd1);
    endtask

    task automatic pop(input int sel);
        if (sel == 0) m0.tready = 1'b1; else m1.tready = 1'b1;
        @(negedge clk);
        m0.tready = 1'b0;
        m1.tready = 1'b0;
    endtask

    // Transmit one word and compare uart_tx at every clock against the expected line image
    task automatic send_and_check(input int sel, input logic [7:0] data, input logic [15:0] exp_bits,
                                  input int nbits, input string tag);
        int   line_err;
        int   busy;
        logic ln, rd;
        line_err = 0;
        busy     = 0;
        chk({tag, " ready before"}, {31'b0, ((sel == 0) ? s0.tready : s1.tready)}, 32'd1);
        if (sel == 0) begin s0.tdata = data; s0.tvalid = 1'b1; end
        else          begin s1.tdata = data[6:0]; s1.tvalid = 1'b1; end
        @(negedge clk);
        s0.tvalid = 1'b0;
        s1.tvalid = 1'b0;
        for (int i = 0; i < nbits * 16; i++) begin
            ln = (sel == 0) ? tx0 : tx1;
            rd = (sel == 0) ? s0.tready : s1.tready;
            if (ln !== exp_bits[i / 16]) line_err++;
            if (rd === 1'b0) busy++;
            @(negedge clk);
        end
        chk({tag, " line"}, line_err, 32'd0);
        chk({tag, " busy clocks"}, busy, nbits * 16);
        chk({tag, " ready after"}, {31'b0, ((sel == 0) ? s0.tready : s1.tready)}, 32'd1);
    endtask

    int got, rerr, ovf_base;

    initial begin
        rst = 1'b1;
        loop0 = 1'b1; loop1 = 1'b1; inj0 = 1'b1; inj1 = 1'b1;
        s0.tdata = '0; s0.tuser = '0; s0.tvalid = 1'b0; m0.tready = 1'b0;
        s1.tdata = '0; s1.tuser = '0; s1.tvalid = 1'b0; m1.tready = 1'b0;
        repeat (4) @(negedge clk);

        // Reset state
        chk("rst uart_tx", {31'b0, tx0}, 32'd1);
        chk("rst s_tready", {31'b0, s0.tready}, 32'd1);
        chk("rst m_tvalid", {31'b0, m0.tvalid}, 32'd0);
        chk("rst m_tdata", {24'b0, m0.tdata}, 32'd0);
        chk("rst m_tuser", {30'b0, m0.tuser}, 32'd0);
        chk("rst overflow", {31'b0, ovf0}, 32'd0);
        chk("rst dut1 tx/ready/valid", {29'b0, tx1, s1.tready, m1.tvalid}, 32'b110);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 0xA5 loopback
        send_and_check(0, 8'hA5, frame8(8'hA5), 10, "8N1 A5");
        wait_valid(0, 64, "8N1 A5 valid");
        chk("8N1 A5 data", {24'b0, m0.tdata}, 32'hA5);
        chk("8N1 A5 user", {30'b0, m0.tuser}, 32'd0);
        pop(0);
        chk("8N1 A5 drained", {31'b0, m0.tvalid}, 32'd0);

        // 7E2 0x55 (four ones -> even parity bit 0), 176 clocks
        send_and_check(1, 8'h55, frame7(7'h55, 1'b0, 1'b1), 11, "7E2 55");
        wait_valid(1, 64, "7E2 55 valid");
        chk("7E2 55 data", {25'b0, m1.tdata}, 32'h55);
        chk("7E2 55 user", {30'b0, m1.tuser}, 32'd0);
        pop(1);

        // Injected parity and framing errors
        loop1 = 1'b0;
        repeat (8) @(negedge clk);
        inj_frame(1, frame7(7'h55, 1'b1, 1'b1), 11);
        wait_valid(1, 64, "perr valid");
        chk("perr data", {25'b0, m1.tdata}, 32'h55);
        chk("perr user", {30'b0, m1.tuser}, 32'b01);
        pop(1);
        inj_frame(1, frame7(7'h55, 1'b0, 1'b0), 11);
        wait_valid(1, 64, "ferr valid");
        chk("ferr data", {25'b0, m1.tdata}, 32'h55);
        chk("ferr user", {30'b0, m1.tuser}, 32'b10);
        pop(1);
        repeat (48) @(negedge clk);
        chk("ferr no extra frame", {31'b0, m1.tvalid}, 32'd0);

        // Start glitch of 4 clocks, then a clean 0x3C
        loop0 = 1'b0;
        repeat (8) @(negedge clk);
        inj0 = 1'b0;
        repeat (4) @(negedge clk);
        inj0 = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch no valid", {31'b0, m0.tvalid}, 32'd0);
        inj_frame(0, frame8(8'h3C), 10);
        wait_valid(0, 64, "3C valid");
        chk("3C data", {24'b0, m0.tdata}, 32'h3C);
        chk("3C user", {30'b0, m0.tuser}, 32'd0);
        pop(0);

        // Overflow: 17 frames into a 16-deep FIFO with ready held low
        ovf_base = ovf_cnt;
        for (int k = 0; k < 17; k++) begin
            cur_frame = k;
            inj_frame(0, frame8(8'(k)), 10);
        end
        repeat (20) @(negedge clk);
        cur_frame = -1;
        chk("ovf pulses", ovf_cnt - ovf_base, 32'd1);
        chk("ovf on frame", ovf_frame, 32'd16);
        m0.tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain %0d", k), {23'b0, m0.tvalid, m0.tdata}, {23'b0, 1'b1, 8'(k)});
            @(negedge clk);
        end
        m0.tready = 1'b0;
        chk("drain empty", {31'b0, m0.tvalid}, 32'd0);

        // Reset during data bit 3 of a 0x00 frame
        loop0 = 1'b1;
        repeat (8) @(negedge clk);
        s0.tdata = 8'h00; s0.tvalid = 1'b1;
        @(negedge clk);
        s0.tvalid = 1'b0;
        repeat (72) @(negedge clk);
        chk("pre-abort line low", {31'b0, tx0}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort uart_tx", {31'b0, tx0}, 32'd1);
        chk("abort ready", {31'b0, s0.tready}, 32'd1);
        repeat (200) @(negedge clk);
        chk("abort rx discarded", {31'b0, m0.tvalid}, 32'd0);
        send_and_check(0, 8'h81, frame8(8'h81), 10, "8N1 81");
        wait_valid(0, 64, "81 valid");
        chk("81 data", {24'b0, m0.tdata}, 32'h81);
        chk("81 user", {30'b0, m0.tuser}, 32'd0);
        pop(0);

        // Random back-to-back loopback, 200 bytes, throttled ready
        got = 0; rerr = 0; ovf_base = ovf_cnt;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    logic [7:0] b;
                    int n;
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    s0.tdata = b; s0.tvalid = 1'b1;
                    n = 0;
                    while (s0.tready !== 1'b1 && n < 400) begin @(negedge clk); n++; end
                    @(negedge clk);
                end
                s0.tvalid = 1'b0;
            end
            begin
                int cyc;
                cyc = 0;
                while (got < 200 && cyc < 40000) begin
                    m0.tready = ($urandom_range(0, 3) != 0);
                    if (m0.tvalid === 1'b1 && m0.tready === 1'b1) begin
                        if (exp_q.size() == 0) rerr++;
                        else if (m0.tdata !== exp_q.pop_front() || m0.tuser !== 2'b00) rerr++;
                        got++;
                    end
                    @(negedge clk);
                    cyc++;
                end
                m0.tready = 1'b0;
            end
        join
        chk("rand received", got, 32'd200);
        chk("rand errors", rerr, 32'd0);
        chk("rand no overflow", ovf_cnt - ovf_base, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
